serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_if.sv | 29 ++
 rtl/Fadd.sv | 15 +
 rtl/serial_adder.sv | 113 +++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
//   start, a, b, cin : request side, driven by the master
//   busy, done, sum, cout : status/result side, driven by the slave (the adder)
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/Fadd.sv
// One-bit full adder.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module Fadd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first, through a
// single full adder. Result appears WIDTH cycles after the accepted start.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_adder_if (start/a/b/cin in, busy/done/sum/cout out)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    // Only WIDTH-1 sum bits need storing; the last one goes straight to sum.
    localparam int unsigned ResW = WIDTH - 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [ResW-1:0]   res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              fa_sum;
    logic              fa_cout;
    logic [WIDTH-1:0]  res_full;

    Fadd u_fadd (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    // New sum bit enters at the MSB end of the partial result.
    assign res_full = {fa_sum, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                res_d   = ResW'(res_full >> 1);
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    sum_d   = res_full;
                    cout_d  = fa_cout;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
